// File: rtl/exp4_gravador_sequencia.sv
// Sequence recorder: captures player moves from the switches
// and writes them in order into a 16x4 RAM for the checker.
module exp4_gravador_sequencia #(
  parameter int PROFUNDIDADE = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] chaves,
  input  logic [3:0] leitura_endereco,
  output logic [3:0] leitura_dado,
  output logic       gravando,
  output logic       pronto,
  output logic       db_we,
  output logic [3:0] db_contagem,
  output logic       db_jogada,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL    = 4'h0,
    PREPARACAO = 4'h1,
    ESPERA     = 4'h2,
    GRAVA      = 4'h4,
    PROXIMO    = 4'h5,
    FIM        = 4'hF
  } estado_t;

  estado_t    estado_q, estado_d;
  logic [3:0] contagem_q, contagem_d;
  logic [3:0] dado_q, dado_d;
  logic [3:0] chaves_ant_q, chaves_ant_d;
  logic [3:0] mem_q [16];

  logic jogada;
  logic fim_c;

  assign jogada = (chaves != 4'h0) && (chaves_ant_q == 4'h0);
  assign fim_c  = (contagem_q == 4'(PROFUNDIDADE - 1));

  always_comb begin
    estado_d     = estado_q;
    contagem_d   = contagem_q;
    dado_d       = dado_q;
    chaves_ant_d = chaves;
    gravando     = 1'b0;
    pronto       = 1'b0;
    db_we        = 1'b0;
    unique case (estado_q)
      INICIAL: begin
        if (iniciar) estado_d = PREPARACAO;
      end
      PREPARACAO: begin
        contagem_d = 4'h0;
        estado_d   = ESPERA;
      end
      ESPERA: begin
        gravando = 1'b1;
        if (jogada) begin
          dado_d   = chaves;
          estado_d = GRAVA;
        end
      end
      GRAVA: begin
        gravando = 1'b1;
        db_we    = 1'b1;
        estado_d = PROXIMO;
      end
      PROXIMO: begin
        gravando = 1'b1;
        if (fim_c) begin
          estado_d = FIM;
        end else begin
          contagem_d = contagem_q + 4'h1;
          estado_d   = ESPERA;
        end
      end
      FIM: begin
        pronto = 1'b1;
        if (iniciar) estado_d = PREPARACAO;
      end
      default: estado_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= INICIAL;
      contagem_q   <= 4'h0;
      dado_q       <= 4'h0;
      chaves_ant_q <= 4'h0;
    end else begin
      estado_q     <= estado_d;
      contagem_q   <= contagem_d;
      dado_q       <= dado_d;
      chaves_ant_q <= chaves_ant_d;
    end
  end

  // RAM is never cleared; reset only blocks a write on the same edge
  always_ff @(posedge clock) begin
    if (!reset && db_we) mem_q[contagem_q] <= dado_q;
  end

  assign leitura_dado = mem_q[leitura_endereco];
  assign db_contagem  = contagem_q;
  assign db_jogada    = jogada;
  assign db_estado    = estado_q;

endmodule
